// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and the iteration counter width helper.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } mdu_state_e;

    // Counter must be able to hold the full divide step count.
    function automatic int mdu_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned restoring divider, one quotient bit per step. The first step is
// taken on the start edge itself, so WIDTH-1 further step pulses finish it.
module mdu_div_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o
);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;

    // Returns {remainder, quotient} after one shift/trial-subtract step; the
    // quotient register doubles as the shift source for the dividend bits.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] rem,
        input logic [WIDTH-1:0] quo,
        input logic [WIDTH-1:0] dvs
    );
        logic [WIDTH:0]   sh;
        logic             take;
        logic [WIDTH-1:0] new_rem;
        sh   = {rem, quo[WIDTH-1]};
        take = (sh >= {1'b0, dvs});
        if (take) begin
            new_rem = sh[WIDTH-1:0] - dvs;
        end else begin
            new_rem = sh[WIDTH-1:0];
        end
        return {new_rem, quo[WIDTH-2:0], take};
    endfunction

    // Datapath registers: load-and-step on start, step on enable, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= {WIDTH{1'b0}};
            quo_q <= {WIDTH{1'b0}};
            dvs_q <= {WIDTH{1'b0}};
        end else if (start_i) begin
            {rem_q, quo_q} <= div_step({WIDTH{1'b0}}, dividend_i, divisor_i);
            dvs_q          <= divisor_i;
        end else if (step_i) begin
            {rem_q, quo_q} <= div_step(rem_q, quo_q, dvs_q);
        end
    end

    assign quo_o = quo_q;
    assign rem_o = rem_q;

endmodule

// File: rtl/mdu_iter.sv
// Shared multiply/divide unit with architectural HI/LO, single request/response
// handshake, and flush that cancels any in-flight operation without side effect.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_op_i,
    input  logic [WIDTH-1:0] req_src1_i,
    input  logic [WIDTH-1:0] req_src2_i,
    input  logic             flush_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic             busy_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = mdu_cnt_width(WIDTH);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   mul_a_q, mul_b_q;
    logic               mul_signed_q;
    logic               is_div_q;
    logic               neg_quo_q, neg_rem_q, div_zero_q;
    logic [WIDTH-1:0]   res_hi_q, res_lo_q;

    logic               accept_s, is_mul_op_s, div_start_s, div_step_s;
    logic               src1_neg_s, src2_neg_s;
    logic [WIDTH-1:0]   abs1_s, abs2_s;
    logic [WIDTH-1:0]   core_quo_s, core_rem_s, fix_quo_s, fix_rem_s;
    logic [2*WIDTH-1:0] ext_a_s, ext_b_s, product_s;

    assign accept_s    = req_valid_i & req_ready_o & ~flush_i;
    assign is_mul_op_s = (req_op_i == MDU_MULT) | (req_op_i == MDU_MULTU);
    assign src1_neg_s  = (req_op_i == MDU_DIV) & req_src1_i[WIDTH-1];
    assign src2_neg_s  = (req_op_i == MDU_DIV) & req_src2_i[WIDTH-1];
    assign abs1_s      = src1_neg_s ? -req_src1_i : req_src1_i;
    assign abs2_s      = src2_neg_s ? -req_src2_i : req_src2_i;

    // Extending to 2*WIDTH makes one unsigned multiply serve both signednesses.
    assign ext_a_s   = mul_signed_q ? {{WIDTH{mul_a_q[WIDTH-1]}}, mul_a_q} : {{WIDTH{1'b0}}, mul_a_q};
    assign ext_b_s   = mul_signed_q ? {{WIDTH{mul_b_q[WIDTH-1]}}, mul_b_q} : {{WIDTH{1'b0}}, mul_b_q};
    assign product_s = ext_a_s * ext_b_s;

    // Divide by zero keeps the all-ones quotient regardless of dividend sign.
    assign fix_quo_s = (neg_quo_q & ~div_zero_q) ? -core_quo_s : core_quo_s;
    assign fix_rem_s = neg_rem_q ? -core_rem_s : core_rem_s;

    mdu_div_core #(
        .WIDTH (WIDTH)
    ) u_div_core (
        .clk        (clk),
        .reset      (reset),
        .start_i    (div_start_s),
        .dividend_i (abs1_s),
        .divisor_i  (abs2_s),
        .step_i     (div_step_s),
        .quo_o      (core_quo_s),
        .rem_o      (core_rem_s)
    );

    // Next-state, counter and HI/LO write selection; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        div_start_s = 1'b0;
        div_step_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (req_op_i)
                        MDU_MULT, MDU_MULTU: begin
                            state_d = (MUL_STAGES == 1) ? ST_DONE : ST_MUL;
                            cnt_d   = CNT_W'(MUL_STAGES - 1);
                        end
                        MDU_DIV, MDU_DIVU: begin
                            div_start_s = 1'b1;
                            state_d     = ST_DIV;
                            cnt_d       = CNT_W'(WIDTH - 1);
                        end
                        MDU_MTHI: hi_d = req_src1_i;
                        MDU_MTLO: lo_d = req_src1_i;
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DIV: begin
                div_step_s = 1'b1;
                cnt_d      = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_DIV;
                end
            end
            ST_FIX: state_d = ST_DONE;
            ST_DONE: begin
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                    hi_d    = is_div_q ? res_hi_q : product_s[2*WIDTH-1:WIDTH];
                    lo_d    = is_div_q ? res_lo_q : product_s[WIDTH-1:0];
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end else begin
            state_d = state_d;
        end
    end

    // State, architectural HI/LO, latched operands and signed results.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            hi_q         <= {WIDTH{1'b0}};
            lo_q         <= {WIDTH{1'b0}};
            mul_a_q      <= {WIDTH{1'b0}};
            mul_b_q      <= {WIDTH{1'b0}};
            mul_signed_q <= 1'b0;
            is_div_q     <= 1'b0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            div_zero_q   <= 1'b0;
            res_hi_q     <= {WIDTH{1'b0}};
            res_lo_q     <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (accept_s && is_mul_op_s) begin
                mul_a_q      <= req_src1_i;
                mul_b_q      <= req_src2_i;
                mul_signed_q <= (req_op_i == MDU_MULT);
                is_div_q     <= 1'b0;
            end
            if (div_start_s) begin
                is_div_q   <= 1'b1;
                neg_quo_q  <= src1_neg_s ^ src2_neg_s;
                neg_rem_q  <= src1_neg_s;
                div_zero_q <= (req_src2_i == {WIDTH{1'b0}});
            end
            if (state_q == ST_FIX) begin
                res_hi_q <= fix_rem_s;
                res_lo_q <= fix_quo_s;
            end
        end
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = (state_q == ST_DONE);
    assign busy_o       = (state_q != ST_IDLE);
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter (WIDTH=32, MUL_STAGES=2): stimulus pushes the
// expected {HI,LO}; a negedge monitor compares them after each response handshake.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] src1, src2;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic        busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic        hs_pend = 1'b0;

    mdu_iter #(
        .WIDTH      (32),
        .MUL_STAGES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_src1_i   (src1),
        .req_src2_i   (src2),
        .flush_i      (flush),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .busy_o       (busy),
        .hi_o         (hi),
        .lo_o         (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor: HI/LO change at the handshake edge, so compare one negedge later.
    always @(negedge clk) begin : mon
        logic [63:0] e;
        if (hs_pend) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected actual=%h expected=none", {hi, lo});
            end else begin
                e = exp_q.pop_front();
                check("resp_hilo", {hi, lo}, e);
            end
        end
        hs_pend <= resp_valid & resp_ready & ~flush & ~reset;
    end

    // Issue one request after the next posedge, then count cycles to resp_valid.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic rdy, input int lat, input string nm);
        int n;
        @(posedge clk); #1;
        resp_ready = rdy;
        req_valid  = 1'b1;
        req_op     = op;
        src1       = a;
        src2       = b;
        @(negedge clk);
        check({"ready_", nm}, {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1;
        while (n < 100) begin
            @(negedge clk);
            if (resp_valid) break;
            @(posedge clk); #1;
            n++;
        end
        check({"latency_", nm}, 64'(n), 64'(lat));
    endtask

    initial begin : stim
        logic saw_valid;
        int   n;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        src1       = 32'd0;
        src2       = 32'd0;
        flush      = 1'b0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_flags", {61'd0, resp_valid, busy, req_ready}, 64'd1);

        exp_q.push_back({32'h0000_0001, 32'hFFFF_FFFD});
        run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 1'b1, 33, "div_7_m2");
        exp_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 2, "multu_max");
        exp_q.push_back({32'h0000_0000, 32'h0000_0001});
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 2, "mult_m1");
        exp_q.push_back({32'd100, 32'hFFFF_FFFF});
        run_op(3'd3, 32'd100, 32'd0, 1'b1, 33, "divu_by0");
        exp_q.push_back({32'h0000_0000, 32'h8000_0000});
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, "div_ovf");

        // -7 / 2 completes while the stage is stalled.
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 33, "div_stall");
        check("stall_hilo0", {hi, lo}, {32'h0, 32'h8000_0000});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("stall_flags", {62'd0, resp_valid, req_ready}, 64'd2);
            check("stall_hilo", {hi, lo}, {32'h0, 32'h8000_0000});
        end
        @(posedge clk); #1 resp_ready = 1'b1;

        // Flush at the tenth divide iteration.
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 3'd2; src1 = 32'd1000; src2 = 32'd3;
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flushdiv_busy", {63'd0, busy}, 64'd0);
        check("flushdiv_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            saw_valid = saw_valid | resp_valid;
        end
        check("flushdiv_noresp", {63'd0, saw_valid}, 64'd0);

        // Flush coinciding with the DONE handshake.
        run_op(3'd1, 32'd2, 32'd3, 1'b0, 2, "multu_flush");
        @(posedge clk); #1;
        resp_ready = 1'b1;
        flush      = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flushdone_state", {62'd0, resp_valid, busy}, 64'd0);
        check("flushdone_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        // MTHI together with flush is not accepted.
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 3'd4; src1 = 32'h0000_1234; flush = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("mthi_flush_hi", {32'h0, hi}, {32'h0, 32'hFFFF_FFFF});

        // Reserved op is accepted and ignored.
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 3'd6; src1 = 32'h5555_5555; src2 = 32'h1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        check("rsvd_state", {63'd0, busy}, 64'd0);
        check("rsvd_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        // MTHI: no same-cycle bypass, visible after the edge.
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 3'd4; src1 = 32'h0000_1234;
        @(negedge clk);
        check("mthi_nobypass", {32'h0, hi}, {32'h0, 32'hFFFF_FFFF});
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        check("mthi_hi", {hi, lo}, {32'h0000_1234, 32'hFFFF_FFFD});

        // Back-to-back MTLO then MULT 3*4.
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 3'd5; src1 = 32'hA5A5_A5A5; src2 = 32'd0;
        @(posedge clk); #1;
        req_op = 3'd0; src1 = 32'd3; src2 = 32'd4;
        exp_q.push_back({32'h0, 32'd12});
        @(negedge clk);
        check("b2b_mtlo", {hi, lo}, {32'h0000_1234, 32'hA5A5_A5A5});
        check("b2b_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        n = 1;
        while (n < 100) begin
            @(negedge clk);
            if (resp_valid) break;
            @(posedge clk); #1;
            n++;
        end
        check("latency_b2b_mult", 64'(n), 64'd2);

        repeat (4) @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
